mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer with architectural HI/LO registers, sitting beside the EXE-stage ALU.
//  Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from ID_EX outputs and runs a 32-step shift-add/restoring-divide.
//  Raises mdu_stall into the hazard logic (ANDed into PC_IF_WR / EX_MEM_WB_WriteRegSel) while HI/LO are not yet valid.
// PARAMETERS
//  LENGTH   32  operand/HI/LO width; iteration count = LENGTH
//  CNT_W    5   iteration counter width, must equal clog2(LENGTH)
// PORTS
//  clk        in   1       pipeline clock, single clock domain
//  rst        in   1       synchronous reset, active-high
//  ex_valid   in   1       EXE-stage instruction valid (0 for bubble/flushed slot)
//  ex_op      in   4       MDU op code, `MDU_OP_* (NOP=0,MULT=1,MULTU=2,DIV=3,DIVU=4,MFHI=5,MFLO=6,MTHI=7,MTLO=8)
//  ex_a       in   LENGTH  forwarded rs (EXE_AluInA_o)
//  ex_b       in   LENGTH  forwarded rt (EXE_AluInB_o)
//  mdu_stall  out  1       hold IF/ID/EXE this cycle; EXE op not accepted
//  mdu_busy   out  1       sequencer not IDLE
//  mdu_done   out  1       one-cycle pulse: HI/LO just updated by MULT/DIV
//  hi         out  LENGTH  HI register (feeds MFHI writeback path)
//  lo         out  LENGTH  LO register (feeds MFLO writeback path)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, hi=lo=0, mdu_busy=mdu_stall=mdu_done=0; rst mid-operation aborts, result discarded, no done pulse.
//  FSM: IDLE -(accepted MULT*/DIV*)-> RUN -(cnt==LENGTH-1)-> FIX -> IDLE. Only IDLE accepts ops.
//  Accept: op accepted at edge T when ex_valid & state==IDLE & op!=NOP; operands |x| latched (signed ops), signs saved.
//  Latency: busy high cycles T+1..T+33 (32 RUN + 1 FIX); hi/lo written at end of FIX, mdu_done=1 in cycle T+34 only.
//  mdu_stall = ex_valid & (ex_op!=NOP) & mdu_busy (combinational); NOP/non-MDU instructions flow freely during RUN.
//  Stalled op held upstream; it is re-presented and accepted in T+34 (state IDLE), seeing updated hi/lo.
//  MTHI/MTLO accepted in IDLE: hi/lo <= ex_a at edge T, visible T+1; no busy, no done.
//  MFHI/MFLO: no state change; hi/lo outputs read combinationally by writeback mux.
//  MULT*: 2*LENGTH product, 1 bit/cycle shift-add; FIX negates product if signs differ (MULT only); hi=upper, lo=lower.
//  DIV*: restoring, 1 quotient bit/cycle; FIX: quotient negated if signs differ, remainder takes dividend sign (DIV only).
//  Divide by zero: completes with normal latency, lo=32'hFFFF_FFFF, hi=ex_a (dividend, unmodified).
//  DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (natural wrap, no trap).
//  cnt counts 0..LENGTH-1 in RUN, cleared on entering FIX; no wrap beyond LENGTH-1.
//  ex_op codes 9..15: treated as NOP.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined: MULT/MULTU computed by single-cycle combinational multiplier, IDLE->FIX directly;
//   busy in T+1 only, mdu_done in T+2; DIV unchanged (33-cycle busy).
//  Undefined: all multiplies use 32-step iterative path as above; no hardware multiplier inferred.
// STRUCTURE
//  Ctrl_encoding_def.v: `MDU_OP_* codes, FSM state codes `MDU_IDLE/`MDU_RUN/`MDU_FIX.
//  Sub-module mdu_div_step: combinational one-bit restoring step (partial rem, divisor -> next rem, quotient bit).
//  Top holds FSM, counter, operand/product regs, sign fix-up, HI/LO regs.
// TESTING
//  MULTU FFFFFFFF*FFFFFFFF at T -> busy T+1..T+33, done T+34, hi=FFFFFFFE lo=00000001.
//  MULT (-3)*7 -> hi=FFFFFFFF lo=FFFFFFEB; DIV (-7)/2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  DIVU 7/0 -> hi=00000007 lo=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000 hi=0, done T+34.
//  MFHI presented T+5..T+34 during DIVU 100/7 -> mdu_stall=1 T+5..T+33, 0 at T+34 with hi=2, lo=14.
//  rst at T+10 of MULT -> T+11 busy=0 hi=lo=0; mdu_done never pulses; new MTLO 0x1234 at T+12 -> lo=1234 at T+13.
//  MDU_FAST_MUL_EN build: MULT 6*7 at T -> busy T+1 only, done T+2, hi=0 lo=0000002A.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op codes, FSM states, default widths and the op-decode helper.
package mdu_seq_pkg;

  localparam int MDU_LENGTH = 32;
  localparam int MDU_CNT_W  = 5;

  typedef enum logic [3:0] {
    MDU_OP_NOP   = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MFHI  = 4'd5,
    MDU_OP_MFLO  = 4'd6,
    MDU_OP_MTHI  = 4'd7,
    MDU_OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // Codes 9..15 behave exactly like NOP, so only 1..8 count as MDU work.
  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         msb_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;

  assign shifted = {rem, msb_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  // No borrow means the divisor fits; the difference then always fits in W bits.
  assign q_bit    = ~diff[W+1];
  assign rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer with architectural HI/LO registers.
// MULT*/DIV* run 32 magnitude steps followed by one sign fix-up cycle;
// MTHI/MTLO write HI/LO directly; MFHI/MFLO only read the outputs.
// Optional build macro MDU_FAST_MUL_EN: multiplies use a single-cycle
// combinational multiplier and skip straight from IDLE to FIX.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int LENGTH = MDU_LENGTH,
  parameter int CNT_W  = MDU_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        ex_op,
  input  logic [LENGTH-1:0] ex_a,
  input  logic [LENGTH-1:0] ex_b,
  output logic              mdu_stall,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [LENGTH-1:0] hi,
  output logic [LENGTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LENGTH - 1);

  mdu_state_e          state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [2*LENGTH-1:0] acc;       // {hi half, lo half}: product, or {remainder, quotient}
  logic [LENGTH-1:0]   opnd;      // |multiplicand| or |divisor|
  logic                op_div;
  logic                neg_q;     // negate product / quotient
  logic                neg_r;     // negate remainder (dividend was negative)
  logic                div0;
  logic                done_q;
  logic [LENGTH-1:0]   hi_q, lo_q;

  // Decode of the op presented by EXE.
  logic              accept, start_mul, start_div, op_signed, sign_a, sign_b;
  logic [LENGTH-1:0] abs_a, abs_b;

  assign accept    = ex_valid && (state == MDU_IDLE) && is_mdu_op(ex_op);
  assign start_mul = accept && ((ex_op == MDU_OP_MULT) || (ex_op == MDU_OP_MULTU));
  assign start_div = accept && ((ex_op == MDU_OP_DIV)  || (ex_op == MDU_OP_DIVU));
  assign op_signed = (ex_op == MDU_OP_MULT) || (ex_op == MDU_OP_DIV);
  assign sign_a    = op_signed & ex_a[LENGTH-1];
  assign sign_b    = op_signed & ex_b[LENGTH-1];
  assign abs_a     = sign_a ? -ex_a : ex_a;
  assign abs_b     = sign_b ? -ex_b : ex_b;

  // Iteration datapaths: one shift-add step and one restoring-divide step.
  logic [LENGTH:0]   mul_sum;
  logic [LENGTH-1:0] rem_next;
  logic              q_bit;

  assign mul_sum = {1'b0, acc[2*LENGTH-1:LENGTH]} + {1'b0, opnd & {LENGTH{acc[0]}}};

  mdu_div_step #(.W(LENGTH)) u_div_step (
    .rem      (acc[2*LENGTH-1:LENGTH]),
    .msb_in   (acc[LENGTH-1]),
    .divisor  (opnd),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // Sign fix-up applied during FIX; divide-by-zero keeps an all-ones quotient.
  logic [2*LENGTH-1:0] prod_fix;
  logic [LENGTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = div0 ? '1 : (neg_q ? -acc[LENGTH-1:0] : acc[LENGTH-1:0]);
  assign rem_fix  = neg_r ? -acc[2*LENGTH-1:LENGTH] : acc[2*LENGTH-1:LENGTH];
  assign res_hi   = op_div ? rem_fix : prod_fix[2*LENGTH-1:LENGTH];
  assign res_lo   = op_div ? quo_fix : prod_fix[LENGTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) state <= MDU_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      MDU_IDLE: begin
        if (start_div) state_next = MDU_RUN;
`ifdef MDU_FAST_MUL_EN
        if (start_mul) state_next = MDU_FIX;
`else
        if (start_mul) state_next = MDU_RUN;
`endif
      end
      MDU_RUN:  if (cnt == CNT_LAST) state_next = MDU_FIX;
      MDU_FIX:  state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  // Operand capture, iteration, counter and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (accept && (ex_op == MDU_OP_MTHI)) hi_q <= ex_a;
          if (accept && (ex_op == MDU_OP_MTLO)) lo_q <= ex_a;
          if (start_mul || start_div) begin
            cnt    <= '0;
            acc    <= {{LENGTH{1'b0}}, abs_a};
            opnd   <= abs_b;
            op_div <= start_div;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= start_div & sign_a;
            div0   <= start_div && (ex_b == '0);
          end
`ifdef MDU_FAST_MUL_EN
          if (start_mul) acc <= {{LENGTH{1'b0}}, abs_a} * {{LENGTH{1'b0}}, abs_b};
`endif
        end
        MDU_RUN: begin
          cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
          if (op_div) acc <= {rem_next, acc[LENGTH-2:0], q_bit};
          else        acc <= {mul_sum, acc[LENGTH-1:1]};
        end
        MDU_FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mdu_busy  = (state != MDU_IDLE);
  assign mdu_stall = ex_valid & is_mdu_op(ex_op) & mdu_busy;
  assign mdu_done  = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus randomized
// op streams; results come from a plain-arithmetic HI/LO model and are
// matched by a monitor against each mdu_done pulse.
module tb_mdu_seq;

  localparam logic [3:0] OP_NOP = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2,
                         OP_DIV = 4'd3, OP_DIVU = 4'd4, OP_MFHI = 4'd5,
                         OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk, rst, ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_a, ex_b;
  logic        mdu_stall, mdu_busy, mdu_done;
  logic [31:0] hi, lo;

  mdu_seq dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .mdu_stall(mdu_stall), .mdu_busy(mdu_busy), .mdu_done(mdu_done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] hi; logic [31:0] lo; int due; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] model_hi = '0, model_lo = '0;

  // Reference: {hi, lo} for MULT*/DIV* straight from integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, qq, rr;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin qq = sa / sb; rr = sa % sb; r = {rr[31:0], qq[31:0]}; end
      end
      OP_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (!rst && mdu_done) begin
      if (sb_q.size() == 0) check("unexpected_done", 1'b1, 1'b0);
      else begin
        mon_e = sb_q.pop_front();
        check("done_hi", hi, mon_e.hi);
        check("done_lo", lo, mon_e.lo);
        check("done_cycle", cyc, mon_e.due);
      end
    end
  end

  // Present one op at a negedge, hold it while stalled, update the model
  // when it is accepted; returns at the following negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    logic [63:0] r;
    exp_t e;
    ex_valid = 1'b1; ex_op = op; ex_a = a; ex_b = b;
    stalls = 0;
    #1;
    while (mdu_stall && stalls < 100) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (stalls >= 100) check("stall_timeout", 1'b1, 1'b0);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        r = ref_result(op, a, b);
        e.hi = r[63:32]; e.lo = r[31:0];
        e.due = cyc + (((op == OP_MULT) || (op == OP_MULTU)) ? MUL_LAT : DIV_LAT);
        sb_q.push_back(e);
        model_hi = r[63:32]; model_lo = r[31:0];
      end
      OP_MTHI: model_hi = a;
      OP_MTLO: model_lo = a;
      OP_MFHI: check("mfhi", hi, model_hi);
      OP_MFLO: check("mflo", lo, model_lo);
      default: ;
    endcase
    @(negedge clk);
    ex_valid = 1'b0; ex_op = OP_NOP;
  endtask

  // Non-MDU traffic: bubbles, NOPs and codes 9..15 must never stall.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0: begin ex_valid = 1'b0; ex_op = 4'($urandom_range(0, 15)); end
        1: begin ex_valid = 1'b1; ex_op = OP_NOP; end
        default: begin ex_valid = 1'b1; ex_op = 4'($urandom_range(9, 15)); end
      endcase
      ex_a = $urandom; ex_b = $urandom;
      #1;
      check("nop_no_stall", mdu_stall, 1'b0);
      @(negedge clk);
    end
    ex_valid = 1'b0; ex_op = OP_NOP;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int st;
  int wait_cnt;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NOP; ex_a = '0; ex_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", mdu_busy, 1'b0);
    check("rst_done", mdu_done, 1'b0);
    check("rst_stall", mdu_stall, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // MULTU all-ones: busy/done timeline relative to the accepting cycle.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
    check("multu_no_stall", st, 0);
    for (int k = 1; k <= 35; k++) begin
      check($sformatf("busy_T+%0d", k), mdu_busy, (k <= MUL_LAT - 1));
      check($sformatf("done_T+%0d", k), mdu_done, (k == MUL_LAT));
      @(negedge clk);
    end
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // Signed multiply/divide with immediate reads (these stall until done).
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, st);
    issue(OP_MFHI, 32'h0, 32'h0, st);
    check("mfhi_after_mult_stalled", st, MUL_LAT - 1);
    issue(OP_MFLO, 32'h0, 32'h0, st);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, st);
    issue(OP_MFLO, 32'h0, 32'h0, st);
    issue(OP_MFHI, 32'h0, 32'h0, st);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero, then the overflow case issued back-to-back.
    issue(OP_DIVU, 32'd7, 32'd0, st);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    check("div_b2b_stall", st, 33);
    issue(OP_MFLO, 32'h0, 32'h0, st);
    check("divov_lo", lo, 32'h8000_0000);
    check("divov_hi", hi, 32'h0);

    // MFHI presented from T+5 during DIVU 100/7.
    issue(OP_DIVU, 32'd100, 32'd7, st);
    idle(4);
    issue(OP_MFHI, 32'h0, 32'h0, st);
    check("mfhi_stall_cycles", st, 29);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);

    // Reset in the middle of a multiply aborts it without a done pulse.
    issue(OP_MULT, 32'd5, 32'd9, st);
    idle(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", mdu_busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    sb_q.delete();
    model_hi = '0; model_lo = '0;
    idle(1);
    issue(OP_MTLO, 32'h0000_1234, 32'h0, st);
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_no_busy", mdu_busy, 1'b0);
    idle(40);

    // Randomized op stream.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(1, 8));
      issue(op, pick_operand(), pick_operand(), st);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    issue(OP_MFHI, 32'h0, 32'h0, st);
    issue(OP_MFLO, 32'h0, 32'h0, st);

    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain_pending", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
